// File: rtl/ti_packet_decoder.sv
// ti_packet_decoder: receive-side Hermes flit parser for the task injector NoC port.
// Optional mid-packet idle watchdog is enabled by defining TI_RX_WATCHDOG_EN.
module ti_packet_decoder #(
  parameter int FLIT_SIZE  = 32,
  parameter int SIZE_WIDTH = 16,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  rx_i,
  input  logic [FLIT_SIZE-1:0]  data_i,
  output logic                  credit_o,
  output logic                  desc_valid_o,
  input  logic                  desc_ack_i,
  output logic [FLIT_SIZE-1:0]  hdr_o,
  output logic [7:0]            service_o,
  output logic                  delivery_o,
  output logic [SIZE_WIDTH-1:0] body_len_o,
  output logic                  pl_valid_o,
  input  logic                  pl_ready_i,
  output logic [FLIT_SIZE-1:0]  pl_data_o,
  output logic                  pl_last_o,
  output logic                  err_o
);

  typedef enum logic [2:0] {
    HEADER  = 3'd0,
    SIZE    = 3'd1,
    SERVICE = 3'd2,
    INNER   = 3'd3,
    DESC    = 3'd4,
    PAYLOAD = 3'd5,
    DROP    = 3'd6
  } state_t;

  localparam logic [SIZE_WIDTH-1:0] CNT_ZERO     = SIZE_WIDTH'(0);
  localparam logic [SIZE_WIDTH-1:0] CNT_ONE      = SIZE_WIDTH'(1);
  localparam logic [SIZE_WIDTH-1:0] CNT_TWO      = SIZE_WIDTH'(2);
  localparam logic [7:0]            SVC_DELIVERY = 8'h43;

  // The watchdog compare needs at least one idle cycle of headroom.
  if (TIMEOUT < 1) begin : g_timeout_check
    $error("ti_packet_decoder: TIMEOUT must be at least 1");
  end

  function automatic logic is_raw_service(input logic [7:0] code);
    case (code)
      8'h40, 8'h41, 8'h42, 8'h43, 8'h51: is_raw_service = 1'b1;
      default:                           is_raw_service = 1'b0;
    endcase
  endfunction

  function automatic logic is_inner_service(input logic [7:0] code);
    case (code)
      8'h00, 8'h01, 8'h02, 8'h06, 8'h10: is_inner_service = 1'b1;
      default:                           is_inner_service = 1'b0;
    endcase
  endfunction

  state_t                  state_r, state_n;
  logic [SIZE_WIDTH-1:0]   cnt_r, cnt_n;
  logic [FLIT_SIZE-1:0]    hdr_r, hdr_n;
  logic [7:0]              service_r, service_n;
  logic                    delivery_r, delivery_n;
  logic [SIZE_WIDTH-1:0]   len_r, len_n;
  logic                    desc_valid_r, desc_valid_n;
  logic                    err_r, err_n;
  logic                    pl_valid_r, pl_valid_n;
  logic [FLIT_SIZE-1:0]    pl_data_r, pl_data_n;
  logic                    pl_last_r, pl_last_n;

  logic                    credit_s;
  logic                    acc_s;
  logic [7:0]              code_s;
  logic [SIZE_WIDTH-1:0]   size_s;

  assign acc_s  = rx_i && credit_s;
  assign code_s = data_i[7:0];
  assign size_s = data_i[SIZE_WIDTH-1:0];

  // Flow control: held low in reset and while a descriptor waits for its ack.
  always_comb begin
    credit_s = 1'b0;
    if (rst_i) begin
      credit_s = 1'b0;
    end else begin
      case (state_r)
        HEADER, SIZE, SERVICE, INNER, DROP: credit_s = 1'b1;
        PAYLOAD:                            credit_s = !pl_valid_r || pl_ready_i;
        DESC:                               credit_s = 1'b0;
        default:                            credit_s = 1'b0;
      endcase
    end
  end

`ifdef TI_RX_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] idle_r, idle_n;
  logic            wd_timeout_s;
  logic            wd_armed_s;

  // Idle counter: only runs while mid-packet and able to accept, holds across consumer stalls.
  always_comb begin
    idle_n       = idle_r;
    wd_timeout_s = 1'b0;
    case (state_r)
      SIZE, SERVICE, INNER, PAYLOAD, DROP: wd_armed_s = 1'b1;
      default:                             wd_armed_s = 1'b0;
    endcase
    if (!wd_armed_s || acc_s) begin
      idle_n = {WD_W{1'b0}};
    end else if (credit_s && !rx_i) begin
      if (idle_r == WD_W'(TIMEOUT - 1)) begin
        wd_timeout_s = 1'b1;
        idle_n       = {WD_W{1'b0}};
      end else begin
        idle_n = idle_r + WD_W'(1);
      end
    end else begin
      idle_n = idle_r;
    end
  end

  // Idle counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idle_r <= {WD_W{1'b0}};
    end else begin
      idle_r <= idle_n;
    end
  end
`endif

  // Next-state and next-output logic for the packet parser.
  always_comb begin
    state_n      = state_r;
    cnt_n        = cnt_r;
    hdr_n        = hdr_r;
    service_n    = service_r;
    delivery_n   = delivery_r;
    len_n        = len_r;
    desc_valid_n = desc_valid_r;
    err_n        = 1'b0;
    pl_valid_n   = pl_valid_r;
    pl_data_n    = pl_data_r;
    pl_last_n    = pl_last_r;

    // The held body flit drains in any state, so the next header can overlap it.
    if (pl_valid_r && pl_ready_i) begin
      pl_valid_n = 1'b0;
      pl_last_n  = 1'b0;
    end else begin
      pl_valid_n = pl_valid_r;
    end

    case (state_r)
      HEADER: begin
        if (acc_s) begin
          hdr_n   = data_i;
          state_n = SIZE;
        end else begin
          state_n = HEADER;
        end
      end
      SIZE: begin
        if (!acc_s) begin
          state_n = SIZE;
        end else if (size_s == CNT_ZERO) begin
          err_n   = 1'b1;
          state_n = HEADER;
        end else begin
          cnt_n   = size_s;
          state_n = SERVICE;
        end
      end
      SERVICE: begin
        if (!acc_s) begin
          state_n = SERVICE;
        end else if (!is_raw_service(code_s)) begin
          err_n = 1'b1;
          if (cnt_r == CNT_ONE) begin
            state_n = HEADER;
          end else begin
            cnt_n   = cnt_r - CNT_ONE;
            state_n = DROP;
          end
        end else if (code_s == SVC_DELIVERY) begin
          if (cnt_r < CNT_TWO) begin
            err_n   = 1'b1;
            state_n = HEADER;
          end else begin
            cnt_n   = cnt_r - CNT_ONE;
            state_n = INNER;
          end
        end else begin
          service_n    = code_s;
          delivery_n   = 1'b0;
          len_n        = cnt_r - CNT_ONE;
          cnt_n        = cnt_r - CNT_ONE;
          desc_valid_n = 1'b1;
          state_n      = DESC;
        end
      end
      INNER: begin
        if (!acc_s) begin
          state_n = INNER;
        end else if (!is_inner_service(code_s)) begin
          err_n = 1'b1;
          if (cnt_r == CNT_ONE) begin
            state_n = HEADER;
          end else begin
            cnt_n   = cnt_r - CNT_ONE;
            state_n = DROP;
          end
        end else begin
          service_n    = code_s;
          delivery_n   = 1'b1;
          len_n        = cnt_r - CNT_ONE;
          cnt_n        = cnt_r - CNT_ONE;
          desc_valid_n = 1'b1;
          state_n      = DESC;
        end
      end
      DESC: begin
        if (desc_ack_i) begin
          desc_valid_n = 1'b0;
          state_n      = (len_r != CNT_ZERO) ? PAYLOAD : HEADER;
        end else begin
          state_n = DESC;
        end
      end
      PAYLOAD: begin
        if (acc_s) begin
          pl_valid_n = 1'b1;
          pl_data_n  = data_i;
          pl_last_n  = (cnt_r == CNT_ONE);
          cnt_n      = cnt_r - CNT_ONE;
          state_n    = (cnt_r == CNT_ONE) ? HEADER : PAYLOAD;
        end else begin
          state_n = PAYLOAD;
        end
      end
      DROP: begin
        if (acc_s) begin
          cnt_n   = cnt_r - CNT_ONE;
          state_n = (cnt_r == CNT_ONE) ? HEADER : DROP;
        end else begin
          state_n = DROP;
        end
      end
      default: begin
        state_n = HEADER;
      end
    endcase

`ifdef TI_RX_WATCHDOG_EN
    if (wd_timeout_s) begin
      err_n      = 1'b1;
      pl_valid_n = 1'b0;
      pl_last_n  = 1'b0;
      state_n    = HEADER;
    end else begin
      err_n = err_n;
    end
`endif
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r      <= HEADER;
      cnt_r        <= CNT_ZERO;
      hdr_r        <= {FLIT_SIZE{1'b0}};
      service_r    <= 8'h00;
      delivery_r   <= 1'b0;
      len_r        <= CNT_ZERO;
      desc_valid_r <= 1'b0;
      err_r        <= 1'b0;
      pl_valid_r   <= 1'b0;
      pl_data_r    <= {FLIT_SIZE{1'b0}};
      pl_last_r    <= 1'b0;
    end else begin
      state_r      <= state_n;
      cnt_r        <= cnt_n;
      hdr_r        <= hdr_n;
      service_r    <= service_n;
      delivery_r   <= delivery_n;
      len_r        <= len_n;
      desc_valid_r <= desc_valid_n;
      err_r        <= err_n;
      pl_valid_r   <= pl_valid_n;
      pl_data_r    <= pl_data_n;
      pl_last_r    <= pl_last_n;
    end
  end

  assign credit_o     = credit_s;
  assign desc_valid_o = desc_valid_r;
  assign hdr_o        = hdr_r;
  assign service_o    = service_r;
  assign delivery_o   = delivery_r;
  assign body_len_o   = len_r;
  assign pl_valid_o   = pl_valid_r;
  assign pl_data_o    = pl_data_r;
  assign pl_last_o    = pl_last_r;
  assign err_o        = err_r;

endmodule

// File: tb/tb_ti_packet_decoder.sv
// Directed self-checking bench for ti_packet_decoder: drives flit packets and
// checks descriptors, the body stream and error pulses against hand-computed values.
module tb_ti_packet_decoder;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        rx_i = 1'b0;
  logic [31:0] data_i = 32'h0;
  logic        credit_o;
  logic        desc_valid_o;
  logic        desc_ack_i = 1'b0;
  logic [31:0] hdr_o;
  logic [7:0]  service_o;
  logic        delivery_o;
  logic [15:0] body_len_o;
  logic        pl_valid_o;
  logic        pl_ready_i = 1'b1;
  logic [31:0] pl_data_o;
  logic        pl_last_o;
  logic        err_o;

  ti_packet_decoder #(.FLIT_SIZE(32), .SIZE_WIDTH(16), .TIMEOUT(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .rx_i(rx_i), .data_i(data_i), .credit_o(credit_o),
    .desc_valid_o(desc_valid_o), .desc_ack_i(desc_ack_i), .hdr_o(hdr_o),
    .service_o(service_o), .delivery_o(delivery_o), .body_len_o(body_len_o),
    .pl_valid_o(pl_valid_o), .pl_ready_i(pl_ready_i), .pl_data_o(pl_data_o),
    .pl_last_o(pl_last_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  int acc_cnt, err_cnt, desc_cycles, credit_in_desc, pl_seen, desc_unstable;
  logic [31:0] pl_q[$];
  logic        last_q[$];
  logic [7:0]  dsvc_q[$];
  logic        ddel_q[$];
  logic [15:0] dlen_q[$];
  logic [31:0] dhdr_q[$];
  logic        prev_dv;
  logic [7:0]  prev_svc;

  logic [31:0] pkt[0:15];
  int          pkt_len;
  int          ack_delay = 0;
  int          ready_mode = 0;

  // Monitor: records handshakes on the falling edge, when everything is settled.
  initial begin
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        if (rx_i && credit_o) acc_cnt++;
        if (err_o) err_cnt++;
        if (desc_valid_o) begin
          desc_cycles++;
          if (credit_o) credit_in_desc++;
          if (prev_dv && (service_o !== prev_svc)) desc_unstable++;
        end
        if (desc_valid_o && desc_ack_i) begin
          dsvc_q.push_back(service_o); ddel_q.push_back(delivery_o);
          dlen_q.push_back(body_len_o); dhdr_q.push_back(hdr_o);
        end
        if (pl_valid_o) pl_seen++;
        if (pl_valid_o && pl_ready_i) begin
          pl_q.push_back(pl_data_o); last_q.push_back(pl_last_o);
        end
      end
      prev_dv  = desc_valid_o;
      prev_svc = service_o;
    end
  end

  // Consumer side: descriptor ack after ack_delay cycles, ready pattern 1,0,0,1 in mode 1.
  initial begin
    int dwait;
    int ridx;
    dwait = 0;
    ridx  = 0;
    forever begin
      @(posedge clk_i); #1;
      if (ready_mode == 1) begin
        pl_ready_i = ((ridx % 4) == 0) || ((ridx % 4) == 3);
        ridx++;
      end else begin
        pl_ready_i = 1'b1;
      end
      if (desc_valid_o && !desc_ack_i) begin
        if (dwait >= ack_delay) desc_ack_i = 1'b1;
        else dwait++;
      end else begin
        desc_ack_i = 1'b0;
        dwait = 0;
      end
    end
  end

  task automatic clear_mon();
    acc_cnt = 0; err_cnt = 0; desc_cycles = 0; credit_in_desc = 0; pl_seen = 0; desc_unstable = 0;
    pl_q.delete(); last_q.delete(); dsvc_q.delete(); ddel_q.delete(); dlen_q.delete(); dhdr_q.delete();
  endtask

  task automatic send_pkt();
    int   idx;
    int   guard;
    logic took;
    idx = 0; guard = 0;
    data_i = pkt[0]; rx_i = 1'b1;
    while (idx < pkt_len && guard < 400) begin
      @(negedge clk_i);
      took = credit_o;
      @(posedge clk_i); #1;
      if (took) begin
        idx++;
        if (idx < pkt_len) data_i = pkt[idx];
        else rx_i = 1'b0;
      end
      guard++;
    end
    rx_i = 1'b0;
    checks++;
    if (idx != pkt_len) begin
      $display("FAIL send_timeout sent %0d of %0d flits", idx, pkt_len); errors++;
    end
  endtask

  task automatic drain(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    checks++; if (credit_o !== 1'b0)     begin $display("FAIL rst_credit got %b exp 0", credit_o); errors++; end
    checks++; if (desc_valid_o !== 1'b0) begin $display("FAIL rst_desc_valid got %b exp 0", desc_valid_o); errors++; end
    checks++; if (pl_valid_o !== 1'b0)   begin $display("FAIL rst_pl_valid got %b exp 0", pl_valid_o); errors++; end
    checks++; if (err_o !== 1'b0)        begin $display("FAIL rst_err got %b exp 0", err_o); errors++; end
    checks++; if (hdr_o !== 32'h0 || service_o !== 8'h0 || body_len_o !== 16'h0)
                begin $display("FAIL rst_fields got hdr %h svc %h len %h exp 0", hdr_o, service_o, body_len_o); errors++; end
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    checks++; if (credit_o !== 1'b1) begin $display("FAIL post_rst_credit got %b exp 1", credit_o); errors++; end
    @(posedge clk_i); #1;
  endtask

  task automatic test_raw();
    clear_mon();
    pkt[0] = 32'h0101; pkt[1] = 32'd3; pkt[2] = 32'h42; pkt[3] = 32'hA; pkt[4] = 32'hB; pkt_len = 5;
    send_pkt(); drain(10);
    checks++; if (dsvc_q.size() !== 1) begin $display("FAIL raw_desc_count got %0d exp 1", dsvc_q.size()); errors++; end
    checks++; if (dsvc_q[0] !== 8'h42)  begin $display("FAIL raw_service got %h exp 42", dsvc_q[0]); errors++; end
    checks++; if (ddel_q[0] !== 1'b0)   begin $display("FAIL raw_delivery got %b exp 0", ddel_q[0]); errors++; end
    checks++; if (dlen_q[0] !== 16'd2)  begin $display("FAIL raw_len got %0d exp 2", dlen_q[0]); errors++; end
    checks++; if (dhdr_q[0] !== 32'h0101) begin $display("FAIL raw_hdr got %h exp 0101", dhdr_q[0]); errors++; end
    checks++; if (pl_q.size() !== 2)    begin $display("FAIL raw_pl_count got %0d exp 2", pl_q.size()); errors++; end
    checks++; if (pl_q[0] !== 32'hA || last_q[0] !== 1'b0) begin $display("FAIL raw_pl0 got %h/%b exp a/0", pl_q[0], last_q[0]); errors++; end
    checks++; if (pl_q[1] !== 32'hB || last_q[1] !== 1'b1) begin $display("FAIL raw_pl1 got %h/%b exp b/1", pl_q[1], last_q[1]); errors++; end
    checks++; if (err_cnt !== 0)        begin $display("FAIL raw_err got %0d exp 0", err_cnt); errors++; end
  endtask

  task automatic test_delivery();
    clear_mon();
    pkt[0] = 32'h0202; pkt[1] = 32'd3; pkt[2] = 32'h43; pkt[3] = 32'h02; pkt[4] = 32'h55; pkt_len = 5;
    send_pkt(); drain(10);
    checks++; if (dsvc_q.size() !== 1 || dsvc_q[0] !== 8'h02) begin $display("FAIL dlv_service got %h (n=%0d) exp 02", dsvc_q[0], dsvc_q.size()); errors++; end
    checks++; if (ddel_q[0] !== 1'b1 || dlen_q[0] !== 16'd1) begin $display("FAIL dlv_del_len got %b/%0d exp 1/1", ddel_q[0], dlen_q[0]); errors++; end
    checks++; if (pl_q.size() !== 1 || pl_q[0] !== 32'h55 || last_q[0] !== 1'b1)
                begin $display("FAIL dlv_pl got n=%0d %h/%b exp 1 55/1", pl_q.size(), pl_q[0], last_q[0]); errors++; end
    checks++; if (err_cnt !== 0) begin $display("FAIL dlv_err got %0d exp 0", err_cnt); errors++; end
  endtask

  task automatic test_zero_body();
    clear_mon();
    pkt[0] = 32'h0303; pkt[1] = 32'd1; pkt[2] = 32'h41;
    pkt[3] = 32'h0404; pkt[4] = 32'd2; pkt[5] = 32'h40; pkt[6] = 32'h77; pkt_len = 7;
    send_pkt(); drain(10);
    checks++; if (dsvc_q.size() !== 2) begin $display("FAIL zb_desc_count got %0d exp 2", dsvc_q.size()); errors++; end
    checks++; if (dsvc_q[0] !== 8'h41 || dlen_q[0] !== 16'd0) begin $display("FAIL zb_desc0 got %h/%0d exp 41/0", dsvc_q[0], dlen_q[0]); errors++; end
    checks++; if (dsvc_q[1] !== 8'h40 || dlen_q[1] !== 16'd1) begin $display("FAIL zb_desc1 got %h/%0d exp 40/1", dsvc_q[1], dlen_q[1]); errors++; end
    checks++; if (pl_seen !== 1 || pl_q[0] !== 32'h77) begin $display("FAIL zb_pl got seen=%0d %h exp 1 77", pl_seen, pl_q[0]); errors++; end
  endtask

  task automatic test_unknown();
    clear_mon();
    pkt[0] = 32'h0505; pkt[1] = 32'd3; pkt[2] = 32'h99; pkt[3] = 32'h1; pkt[4] = 32'h2;
    pkt_len = 5;
    send_pkt(); drain(6);
    checks++; if (err_cnt !== 1) begin $display("FAIL unk_err got %0d exp 1", err_cnt); errors++; end
    checks++; if (acc_cnt !== 5 || dsvc_q.size() !== 0 || pl_seen !== 0)
                begin $display("FAIL unk_drop got acc=%0d desc=%0d pl=%0d exp 5 0 0", acc_cnt, dsvc_q.size(), pl_seen); errors++; end
    clear_mon();
    pkt[0] = 32'h0606; pkt[1] = 32'd0;
    pkt[2] = 32'h0707; pkt[3] = 32'd2; pkt[4] = 32'h51; pkt[5] = 32'h88; pkt_len = 6;
    send_pkt(); drain(8);
    checks++; if (err_cnt !== 1) begin $display("FAIL s0_err got %0d exp 1", err_cnt); errors++; end
    checks++; if (dsvc_q.size() !== 1 || dsvc_q[0] !== 8'h51 || dhdr_q[0] !== 32'h0707)
                begin $display("FAIL s0_next got n=%0d %h hdr %h exp 1 51 0707", dsvc_q.size(), dsvc_q[0], dhdr_q[0]); errors++; end
    checks++; if (pl_q.size() !== 1 || pl_q[0] !== 32'h88) begin $display("FAIL s0_pl got n=%0d %h exp 1 88", pl_q.size(), pl_q[0]); errors++; end
  endtask

  task automatic test_bad_inner();
    clear_mon();
    pkt[0] = 32'h0808; pkt[1] = 32'd3; pkt[2] = 32'h43; pkt[3] = 32'h07; pkt[4] = 32'h09;
    pkt[5] = 32'h0909; pkt[6] = 32'd1; pkt[7] = 32'h43;
    pkt[8] = 32'h0A0A; pkt[9] = 32'd2; pkt[10] = 32'h42; pkt[11] = 32'h66; pkt_len = 12;
    send_pkt(); drain(8);
    checks++; if (err_cnt !== 2 || acc_cnt !== 12) begin $display("FAIL inner_err got err=%0d acc=%0d exp 2 12", err_cnt, acc_cnt); errors++; end
    checks++; if (dsvc_q.size() !== 1 || dsvc_q[0] !== 8'h42 || pl_q.size() !== 1 || pl_q[0] !== 32'h66)
                begin $display("FAIL inner_next got n=%0d %h pl n=%0d %h exp 1 42 1 66", dsvc_q.size(), dsvc_q[0], pl_q.size(), pl_q[0]); errors++; end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_d[5];
    logic        exp_l[5];
    exp_d = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55};
    exp_l = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    clear_mon();
    ready_mode = 1; ack_delay = 5;
    pkt[0] = 32'h0B0B; pkt[1] = 32'd5; pkt[2] = 32'h42; pkt[3] = 32'h11; pkt[4] = 32'h22;
    pkt[5] = 32'h33; pkt[6] = 32'h44; pkt[7] = 32'h0C0C; pkt[8] = 32'd2; pkt[9] = 32'h40;
    pkt[10] = 32'h55; pkt_len = 11;
    send_pkt(); drain(30);
    ready_mode = 0; ack_delay = 0;
    checks++; if (credit_in_desc !== 0) begin $display("FAIL bp_credit_desc got %0d exp 0", credit_in_desc); errors++; end
    checks++; if (desc_cycles < 10 || desc_unstable !== 0) begin $display("FAIL bp_desc_hold got cycles=%0d unstable=%0d exp >=10 0", desc_cycles, desc_unstable); errors++; end
    checks++; if (dlen_q.size() !== 2 || dlen_q[0] !== 16'd4 || dlen_q[1] !== 16'd1)
                begin $display("FAIL bp_len got n=%0d %0d %0d exp 2 4 1", dlen_q.size(), dlen_q[0], dlen_q[1]); errors++; end
    checks++; if (pl_q.size() !== 5) begin $display("FAIL bp_pl_count got %0d exp 5", pl_q.size()); errors++; end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (pl_q[i] !== exp_d[i] || last_q[i] !== exp_l[i])
        begin $display("FAIL bp_pl%0d got %h/%b exp %h/%b", i, pl_q[i], last_q[i], exp_d[i], exp_l[i]); errors++; end
    end
  endtask

  task automatic test_watchdog();
    clear_mon();
    pkt[0] = 32'h0D0D; pkt[1] = 32'd4; pkt[2] = 32'h42; pkt[3] = 32'h31; pkt_len = 4;
    send_pkt(); drain(20);
    checks++; if (pl_q.size() !== 1 || pl_q[0] !== 32'h31) begin $display("FAIL wd_first got n=%0d %h exp 1 31", pl_q.size(), pl_q[0]); errors++; end
`ifdef TI_RX_WATCHDOG_EN
    checks++; if (err_cnt !== 1) begin $display("FAIL wd_err got %0d exp 1", err_cnt); errors++; end
    pkt[0] = 32'h0E0E; pkt[1] = 32'd2; pkt[2] = 32'h41; pkt[3] = 32'h32; pkt_len = 4;
    send_pkt(); drain(10);
    checks++; if (dsvc_q.size() !== 2 || dsvc_q[1] !== 8'h41 || dhdr_q[1] !== 32'h0E0E)
                begin $display("FAIL wd_next got n=%0d %h hdr %h exp 2 41 0e0e", dsvc_q.size(), dsvc_q[1], dhdr_q[1]); errors++; end
    checks++; if (pl_q.size() !== 2 || pl_q[1] !== 32'h32 || last_q[1] !== 1'b1)
                begin $display("FAIL wd_next_pl got n=%0d %h/%b exp 2 32/1", pl_q.size(), pl_q[1], last_q[1]); errors++; end
`else
    checks++; if (err_cnt !== 0) begin $display("FAIL nowd_err got %0d exp 0", err_cnt); errors++; end
    pkt[0] = 32'h21; pkt[1] = 32'h22; pkt_len = 2;
    send_pkt(); drain(10);
    checks++; if (pl_q.size() !== 3 || pl_q[2] !== 32'h22 || last_q[2] !== 1'b1 || err_cnt !== 0)
                begin $display("FAIL nowd_resume got n=%0d %h/%b err=%0d exp 3 22/1 0", pl_q.size(), pl_q[2], last_q[2], err_cnt); errors++; end
`endif
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_raw();
    test_delivery();
    test_zero_body();
    test_unknown();
    test_bad_inner();
    test_back_to_back();
    test_watchdog();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ti_packet_decoder.md
Name: ti_packet_decoder

Overview:
- Receive-side decoder for the task injector's NoC port: accepts Hermes-style flits arriving at the injector (rx/credit handshake) and parses the packet.
- Validates and reports the service code (raw or inside MESSAGE_DELIVERY) to the injector control FSM as a descriptor.
- Streams the remaining body flits to the consumer.
- Mirror of the injector's packet builder: that block transmits, this block receives.

Parameters:
- FLIT_SIZE, 32, flit/data width in bits.
- SIZE_WIDTH, 16, width of the size counter; size flit bits [SIZE_WIDTH-1:0] are used.
- TIMEOUT, 1024, idle-cycle limit mid-packet (used only with TI_RX_WATCHDOG_EN).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- rx_i  in  1  flit valid from router
- data_i  in  FLIT_SIZE  flit
- credit_o  out  1  flit accepted this cycle when rx_i && credit_o
- desc_valid_o  out  1  descriptor valid
- desc_ack_i  in  1  descriptor consumed
- hdr_o  out  FLIT_SIZE  captured header (target) flit
- service_o  out  8  decoded service
- delivery_o  out  1  service_o came from inside MESSAGE_DELIVERY
- body_len_o  out  SIZE_WIDTH  number of body flits that will stream
- pl_valid_o  out  1  body flit valid
- pl_ready_i  in  1  body flit accepted
- pl_data_o  out  FLIT_SIZE  body flit
- pl_last_o  out  1  final body flit
- err_o  out  1  one-cycle pulse: malformed/unknown packet

Behaviour:
- Packet format: flit0 header; flit1 size S (flits that follow); flit2 service in bits [7:0]; then S-1 body flits. For MESSAGE_DELIVERY (0x43), the first body flit is the inner service; the remaining S-2 flits stream.
- Valid raw services: 0x40, 0x41, 0x42, 0x43, 0x51. Valid inner services: 0x00, 0x01, 0x02, 0x06, 0x10.
- FSM states: HEADER, SIZE, SERVICE, INNER, DESC, PAYLOAD, DROP.
- HEADER: credit_o=1; on a flit, capture hdr_o and go to SIZE.
- SIZE: capture S.
  - S==0: err_o pulse, go to HEADER.
  - Otherwise go to SERVICE.
- SERVICE:
  - Unknown code: err_o pulse; go to DROP with remaining count S-1, or to HEADER if S==1.
  - 0x43 with S<2: err_o, go to HEADER.
  - 0x43 otherwise: go to INNER.
  - Any other valid code: service_o=code, delivery_o=0, body_len_o=S-1, go to DESC.
- INNER:
  - Unknown inner code: err_o, then DROP with S-2 remaining, or HEADER if 0.
  - Otherwise: service_o=inner code, delivery_o=1, body_len_o=S-2, go to DESC.
- DESC: desc_valid_o=1, credit_o=0. On desc_ack_i, go to PAYLOAD if body_len_o>0, else HEADER. Descriptor fields are stable while desc_valid_o=1.
- PAYLOAD:
  - One-entry output register; credit_o = !pl_valid_o || pl_ready_i, so full throughput of 1 flit/cycle.
  - pl_last_o=1 on the flit where the remaining count reaches 0.
  - After the last flit is accepted into the register, go to HEADER. The header of the next packet may be accepted while the last flit is still held.
- DROP: credit_o=1; consume flits, decrement the count, go to HEADER at 0. Nothing is presented on pl_*.
- Counter is SIZE_WIDTH bits, never wraps: transitions occur at the 0 check.
- Reset: state HEADER; all outputs 0 (credit_o=0 during reset, 1 the cycle after). Reset mid-packet discards everything; the rest of that packet is then parsed as a new packet (system-level responsibility).
- desc_ack_i outside DESC is ignored. pl_ready_i with pl_valid_o=0 is ignored.

Optional Feature:
- Macro TI_RX_WATCHDOG_EN.
- With it: in SIZE, SERVICE, INNER, PAYLOAD and DROP, an idle counter increments on each cycle with credit_o=1 and no rx_i. It clears on any accepted flit.
  - Reaching TIMEOUT: err_o pulse, pl_valid_o cleared, FSM goes to HEADER.
  - DESC, and PAYLOAD cycles stalled by pl_ready_i=0, do not count.
- Without it: no counter; the decoder waits indefinitely.

Test Plan:
- Raw TASK_ALLOCATION: flits {0x0101, 3, 0x42, 0xA, 0xB} with immediate ack and ready -> descriptor service 0x42, delivery 0, len 2, hdr 0x0101; pl stream 0xA then 0xB with last on 0xB; no err.
- MESSAGE_DELIVERY/APP_MAPPING_COMPLETE: {H, 3, 0x43, 0x02, 0x55} -> service 0x02, delivery 1, len 1; single flit 0x55 with last.
- Zero body: {H, 1, 0x41} -> descriptor len 1-1=0; after ack no pl_valid_o; next packet parsed back-to-back.
- Unknown service: {H, 3, 0x99, x, y} -> err pulse once, both flits consumed with credit high, no descriptor, no pl_valid_o. Same check for S=0.
- Backpressure: 4-flit body with pl_ready_i toggling 1,0,0,1,... and desc_ack_i delayed 5 cycles -> credit_o=0 during DESC; data order and count exact; no flit lost or duplicated.
- Watchdog (macro on, TIMEOUT=8): stop rx after 1 of 3 body flits -> err at 8 idle cycles; next packet decodes correctly. Macro off: waits indefinitely.
